// File: rtl/ball_pkg.sv
`default_nettype none
// =============================================================================
//  Package     : ball_pkg
//  Description : Shared ball-tree constants, controller state type and helpers.
//  Revision    : 1.0 - initial release
// =============================================================================
package ball_pkg;

    localparam int LEVELS    = 3;
    localparam int NUM_SLOTS = 2**LEVELS - 1;

    // Pixel code the ball bitmaps treat as "no colour here".
    localparam logic [7:0] TRANSPARENT_ENCODING = 8'hFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PICK    = 2'd1,
        SPAWN_L = 2'd2,
        SPAWN_R = 2'd3
    } ctrl_state_t;

    // Depth of a slot in the heap-ordered split tree (0 = huge ball).
    function automatic int slot_level(input int idx);
        int lvl;
        lvl = 0;
        for (int l = 1; l < 16; l++) begin
            if (idx + 1 >= (1 << l)) begin
                lvl = l;
            end
        end
        return lvl;
    endfunction

    function automatic logic is_leaf(input int idx, input int levels = LEVELS);
        return slot_level(idx) >= levels - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lowest_bit_picker.sv
`default_nettype none
// =============================================================================
//  Module      : lowest_bit_picker
//  Description : Priority encoder returning the lowest set bit index of vec_i.
//  Revision    : 1.0 - initial release
// =============================================================================
module lowest_bit_picker #(
    parameter int N     = 7,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
        valid_o = |vec_i;
    end

endmodule
`default_nettype wire

// File: rtl/ball_split_controller.sv
`default_nettype none
// =============================================================================
//  Module      : ball_split_controller
//  Description : Owns ball slot liveness; pops/splits hit balls at frame start.
//  Revision    : 1.0 - initial release
// =============================================================================
module ball_split_controller
    import ball_pkg::*;
#(
    parameter  int LEVELS    = ball_pkg::LEVELS,
    localparam int NUM_SLOTS = 2**LEVELS - 1,
    localparam int IDX_W     = $clog2(NUM_SLOTS)
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 startLevel,
    input  logic                 startOfFrame,
    input  logic [NUM_SLOTS-1:0] hit,
    output logic [NUM_SLOTS-1:0] active,
    output logic [NUM_SLOTS-1:0] spawnPulse,
    output logic                 spawnDirRight,
    output logic [IDX_W-1:0]     parentIdx,
    output logic                 scoreValid,
    output logic [3:0]           scoreValue,
    output logic                 levelCleared,
    output logic                 busy
);

    ctrl_state_t          state_q, state_d;
    logic [NUM_SLOTS-1:0] active_q, active_d;
    logic [NUM_SLOTS-1:0] pending_q, pending_d;
    logic                 armed_q, armed_d;
    logic [IDX_W-1:0]     cur_q, cur_d;
    logic [NUM_SLOTS-1:0] spawn_q, spawn_d;
    logic                 dir_q, dir_d;
    logic [IDX_W-1:0]     parent_q, parent_d;
    logic                 score_valid_q, score_valid_d;
    logic [3:0]           score_value_q, score_value_d;
    logic                 cleared_q, cleared_d;

    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_valid;
    logic [NUM_SLOTS-1:0] pick_rest;
    logic [IDX_W-1:0]     left_idx;
    logic [IDX_W-1:0]     right_idx;

    lowest_bit_picker #(
        .N     (NUM_SLOTS),
        .IDX_W (IDX_W)
    ) u_picker (
        .vec_i   (pending_q),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    assign pick_rest = pending_q & ~(NUM_SLOTS'(1) << pick_idx);
    assign left_idx  = IDX_W'(2 * int'(cur_q) + 1);
    assign right_idx = IDX_W'(2 * int'(cur_q) + 2);

    always_comb begin
        state_d       = state_q;
        active_d      = active_q;
        // Masking with the registered active vector drops hits on dead slots
        // and on a child in the very cycle its spawn is being registered.
        pending_d     = pending_q | (hit & active_q);
        armed_d       = armed_q;
        cur_d         = cur_q;
        spawn_d       = '0;
        dir_d         = 1'b0;
        parent_d      = '0;
        score_valid_d = 1'b0;
        score_value_d = '0;
        cleared_d     = armed_q && (active_q == '0) && (pending_q == '0) && (state_q == IDLE);

        case (state_q)
            IDLE: begin
                if (startOfFrame && (pending_q != '0)) begin
                    state_d = PICK;
                end
            end
            PICK: begin
                if (pick_valid) begin
                    active_d[pick_idx]  = 1'b0;
                    pending_d[pick_idx] = 1'b0;
                    cur_d               = pick_idx;
                    score_valid_d       = 1'b1;
                    score_value_d       = 4'(1 << slot_level(int'(pick_idx)));
                    if (is_leaf(int'(pick_idx), LEVELS)) begin
                        state_d = (pick_rest != '0) ? PICK : IDLE;
                    end else begin
                        state_d = SPAWN_L;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SPAWN_L: begin
                active_d[left_idx] = 1'b1;
                spawn_d[left_idx]  = 1'b1;
                dir_d              = 1'b0;
                parent_d           = cur_q;
                state_d            = SPAWN_R;
            end
            SPAWN_R: begin
                active_d[right_idx] = 1'b1;
                spawn_d[right_idx]  = 1'b1;
                dir_d               = 1'b1;
                parent_d            = cur_q;
                state_d             = (pending_q != '0) ? PICK : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (startLevel) begin
            state_d       = IDLE;
            active_d      = NUM_SLOTS'(1);
            pending_d     = '0;
            armed_d       = 1'b1;
            spawn_d       = '0;
            dir_d         = 1'b0;
            parent_d      = '0;
            score_valid_d = 1'b0;
            score_value_d = '0;
            cleared_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (resetN) begin
            state_q       <= IDLE;
            active_q      <= '0;
            pending_q     <= '0;
            armed_q       <= 1'b0;
            cur_q         <= '0;
            spawn_q       <= '0;
            dir_q         <= 1'b0;
            parent_q      <= '0;
            score_valid_q <= 1'b0;
            score_value_q <= '0;
            cleared_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            active_q      <= active_d;
            pending_q     <= pending_d;
            armed_q       <= armed_d;
            cur_q         <= cur_d;
            spawn_q       <= spawn_d;
            dir_q         <= dir_d;
            parent_q      <= parent_d;
            score_valid_q <= score_valid_d;
            score_value_q <= score_value_d;
            cleared_q     <= cleared_d;
        end
    end

    assign active        = active_q;
    assign spawnPulse    = spawn_q;
    assign spawnDirRight = dir_q;
    assign parentIdx     = parent_q;
    assign scoreValid    = score_valid_q;
    assign scoreValue    = score_value_q;
    assign levelCleared  = cleared_q;
    assign busy          = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ball_split_controller.sv
`default_nettype none
// =============================================================================
//  Module      : tb_ball_split_controller
//  Description : Scoreboard bench for the ball split controller.
//  Revision    : 1.0 - initial release
// =============================================================================
module tb_ball_split_controller;

    logic       clk = 1'b0;
    logic       resetN;
    logic       startLevel;
    logic       startOfFrame;
    logic [6:0] hit;
    logic [6:0] active;
    logic [6:0] spawnPulse;
    logic       spawnDirRight;
    logic [2:0] parentIdx;
    logic       scoreValid;
    logic [3:0] scoreValue;
    logic       levelCleared;
    logic       busy;

    ball_split_controller dut (
        .clk           (clk),
        .resetN        (resetN),
        .startLevel    (startLevel),
        .startOfFrame  (startOfFrame),
        .hit           (hit),
        .active        (active),
        .spawnPulse    (spawnPulse),
        .spawnDirRight (spawnDirRight),
        .parentIdx     (parentIdx),
        .scoreValid    (scoreValid),
        .scoreValue    (scoreValue),
        .levelCleared  (levelCleared),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit is_spawn;
        int mask;
        int dir;
        int parent;
        int score;
        int at;
    } ev_t;

    ev_t        exp_q[$];
    int         n_checks   = 0;
    int         n_fail     = 0;
    int         busy_total = 0;
    logic [6:0] m_act      = '0;
    logic [6:0] m_pend     = '0;
    bit         m_armed    = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input int want);
        n_checks++;
        if (got !== 32'(want)) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_score(input int at, input int pts);
        ev_t e;
        e = '{is_spawn: 1'b0, mask: 0, dir: 0, parent: 0, score: pts, at: at};
        exp_q.push_back(e);
    endtask

    task automatic push_spawn(input int at, input int child, input int dir, input int parent);
        ev_t e;
        e = '{is_spawn: 1'b1, mask: (1 << child), dir: dir, parent: parent, score: 0, at: at};
        exp_q.push_back(e);
    endtask

    // Reference: pop every pending ball lowest-first; big/huge balls split into
    // two children. Each pop costs one cycle, each split two more.
    task automatic model_frame(input int s, output int busy_exp);
        int t;
        int p;
        int lvl;
        t = s + 2;
        while (m_pend != 0) begin
            p = 0;
            for (int i = 6; i >= 0; i--) begin
                if (m_pend[i]) p = i;
            end
            lvl = (p == 0) ? 0 : ((p <= 2) ? 1 : 2);
            push_score(t, 1 << lvl);
            m_act[p]  = 1'b0;
            m_pend[p] = 1'b0;
            if (p < 3) begin
                push_spawn(t + 1, 2 * p + 1, 0, p);
                push_spawn(t + 2, 2 * p + 2, 1, p);
                m_act[2 * p + 1] = 1'b1;
                m_act[2 * p + 2] = 1'b1;
                t = t + 3;
            end else begin
                t = t + 1;
            end
        end
        busy_exp = t - (s + 2);
    endtask

    task automatic monitor();
        ev_t e;
        forever begin
            @(negedge clk);
            if (busy) busy_total++;
            if (scoreValid || (spawnPulse != '0)) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: got scoreValid=%0b spawnPulse=%b, expected no event (cycle %0d)",
                             scoreValid, spawnPulse, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_cycle", 32'(cyc), e.at);
                    chk("event_scoreValid", 32'(scoreValid), e.is_spawn ? 0 : 1);
                    chk("event_spawnPulse", 32'(spawnPulse), e.is_spawn ? e.mask : 0);
                    if (e.is_spawn) begin
                        chk("spawnDirRight", 32'(spawnDirRight), e.dir);
                        chk("parentIdx", 32'(parentIdx), e.parent);
                    end else begin
                        chk("scoreValue", 32'(scoreValue), e.score);
                    end
                end
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_active"}, 32'(active), 0);
        chk({tag, "_spawnPulse"}, 32'(spawnPulse), 0);
        chk({tag, "_spawnDirRight"}, 32'(spawnDirRight), 0);
        chk({tag, "_parentIdx"}, 32'(parentIdx), 0);
        chk({tag, "_scoreValid"}, 32'(scoreValid), 0);
        chk({tag, "_scoreValue"}, 32'(scoreValue), 0);
        chk({tag, "_levelCleared"}, 32'(levelCleared), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    task automatic start_level();
        startLevel = 1'b1;
        step();
        startLevel = 1'b0;
        m_act   = 7'b0000001;
        m_pend  = '0;
        m_armed = 1'b1;
        @(negedge clk);
        chk("startLevel_active", 32'(active), 1);
        chk("startLevel_cleared", 32'(levelCleared), 0);
        step();
    endtask

    task automatic frame(input logic [6:0] h1, input logic [6:0] h2);
        int s;
        int busy_exp;
        int thr;
        int b0;
        bit was_empty;
        bit exp_lc;
        hit = h1;
        m_pend = m_pend | (h1 & m_act);
        step();
        hit = h2;
        m_pend = m_pend | (h2 & m_act);
        step();
        hit = '0;
        step();
        was_empty = m_armed && (m_act == 0) && (m_pend == 0);
        startOfFrame = 1'b1;
        s  = cyc;
        b0 = busy_total;
        model_frame(s, busy_exp);
        thr = s + 2 + busy_exp;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            exp_lc = m_armed && (m_act == 0) && (was_empty || (cyc >= thr));
            chk("levelCleared", 32'(levelCleared), int'(exp_lc));
            step();
            startOfFrame = 1'b0;
        end
        chk("busy_cycles", 32'(busy_total - b0), busy_exp);
        chk("events_drained", 32'(exp_q.size()), 0);
        chk("frame_active", 32'(active), int'(m_act));
    endtask

    task automatic mid_reset();
        int s;
        start_level();
        hit = 7'b0000001;
        step();
        hit = '0;
        step();
        startOfFrame = 1'b1;
        s = cyc;
        push_score(s + 2, 1);
        step();
        startOfFrame = 1'b0;
        step();
        resetN = 1'b1;
        step();
        resetN = 1'b0;
        m_act   = '0;
        m_pend  = '0;
        m_armed = 1'b0;
        @(negedge clk);
        check_idle_outputs("midReset");
        repeat (6) step();
        chk("midReset_drained", 32'(exp_q.size()), 0);
        chk("midReset_active_after", 32'(active), 0);
    endtask

    task automatic mid_start_level();
        int s;
        start_level();
        hit = 7'b0000001;
        step();
        hit = '0;
        step();
        startOfFrame = 1'b1;
        s = cyc;
        push_score(s + 2, 1);
        push_spawn(s + 3, 1, 0, 0);
        step();
        startOfFrame = 1'b0;
        step();
        step();
        startLevel = 1'b1;
        step();
        startLevel = 1'b0;
        m_act   = 7'b0000001;
        m_pend  = '0;
        m_armed = 1'b1;
        @(negedge clk);
        chk("midStart_active", 32'(active), 1);
        chk("midStart_spawnPulse", 32'(spawnPulse), 0);
        chk("midStart_scoreValid", 32'(scoreValid), 0);
        repeat (6) step();
        chk("midStart_drained", 32'(exp_q.size()), 0);
        chk("midStart_active_after", 32'(active), 1);
    endtask

    initial begin
        resetN       = 1'b1;
        startLevel   = 1'b0;
        startOfFrame = 1'b0;
        hit          = '0;
        fork
            monitor();
        join_none
        repeat (3) step();
        resetN = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");
        step();

        start_level();
        frame(7'b0000001, 7'b0000000);
        frame(7'b0000110, 7'b0000110);
        frame(7'b1110000, 7'b0000000);
        frame(7'b0100000, 7'b0000000);
        frame(7'b0001000, 7'b0000000);
        frame(7'b0000000, 7'b0000000);

        mid_reset();
        mid_start_level();

        for (int lv = 0; lv < 6; lv++) begin
            start_level();
            for (int f = 0; (f < 10) && (m_act != 0); f++) begin
                frame(7'($urandom_range(0, 127)),
                      ($urandom_range(0, 1) == 1) ? 7'($urandom_range(0, 127)) : 7'd0);
            end
            frame(7'h7f, 7'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
